req_grant_arbiter: RTL and testbench
====================================

// Module: req_grant_arbiter
// PURPOSE
//  Responder side of the request/grant handshake: takes NUM_REQ request lines,
//  issues at most one grant using round-robin priority, and enforces a bounded
//  hold time per grant. It sits between requesters and a shared resource.
//  The grant-implies-request rule (CHK_GNT_HAS_REQ) and grant one-hotness
//  (CHK_GNT_ONEHOT) are enforced by construction and checked by immediate
//  assertions in a posedge clk always block.
// PARAMETERS
//  NUM_REQ   4  number of requesters, 2..16
//  MAX_HOLD  8  max consecutive cycles one grant is held, 1..255
// PORTS
//  clk         in   1        clock; all state updates on posedge clk
//  reset       in   1        asynchronous, active-high reset
//  request     in   NUM_REQ  request[i]=1: requester i wants the resource
//  grant       out  NUM_REQ  one-hot or zero; grant[i] = gnt_q[i] & request[i]
//  grant_valid out  1        |grant
//  grant_id    out  $clog2(NUM_REQ)  index of the registered grant; 0 when idle
//  timeout     out  1        1-cycle pulse when a grant is revoked at MAX_HOLD
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, gnt_q=0, ptr=0, hold_cnt=0.
//   grant=0, grant_valid=0, grant_id=0, timeout=0.
//  Round-robin pick: search from ptr upward, mod NUM_REQ.
//   The first index with request=1 wins.
//  FSM states:
//   IDLE:    if |request: gnt_q<=onehot(pick), hold_cnt<=1, ->GRANT; else stay.
//   GRANT:   if request[grant_id]==0: gnt_q<=0, ptr<=grant_id+1 (wrap), ->IDLE.
//            elif hold_cnt==MAX_HOLD: gnt_q<=0, ptr<=grant_id+1, timeout<=1,
//            ->RELEASE.
//            else hold_cnt<=hold_cnt+1, stay.
//   RELEASE: gnt_q=0 for exactly 1 cycle, timeout<=0, ->IDLE.
//  Latency: request seen at edge N gives grant high in the cycle after edge N.
//   With no contention that is 1 cycle.
//  Request drop: grant is masked combinationally in the same cycle, so grant
//   never asserts without request. gnt_q clears at the next edge.
//  Re-grant gap: at least 1 idle cycle between grants. It is 2 cycles after a
//   timeout (RELEASE, then IDLE).
//  A timed-out requester keeps its request asserted and is re-served only after
//   the other active requesters, since ptr has advanced past it.
//  hold_cnt width is 8 bits. It never exceeds MAX_HOLD and has no wrap.
//  Simultaneous drop and timeout: drop wins, ->IDLE, timeout stays 0.
//  Reset mid-grant: grant drops asynchronously. ptr returns to 0.
//  Assertions run in GRANT state only; X on request is not checked.
// TESTING
//  1 Reset. request=4'b0000 for 5 cycles
//    -> grant=0, grant_valid=0, timeout=0 throughout.
//  2 request=4'b0010 at cycle 4, dropped at cycle 7
//    -> grant=4'b0010 in cycles 5-6; grant=0 in cycle 7 (same cycle);
//       state IDLE from cycle 8.
//  3 request=4'b1111 held, MAX_HOLD=8
//    -> grants 0,1,2,3,0 in that order, each held 8 cycles.
//       timeout pulses once per grant; 2 idle cycles between grants.
//  4 request=4'b0101 held; req0 drops after 3 cycles of grant
//    -> grant moves to 4'b0100 after 1 idle cycle; ptr=1 then 3.
//  5 request=4'b0001 held 20 cycles, MAX_HOLD=8, no other requests
//    -> grant pattern 8 on / 2 off, repeating; timeout at cycles 9 and 19.
//  6 Assert reset while grant=4'b1000
//    -> grant=0 immediately. After release with request=4'b1001, grant=4'b0001.
//  All runs: CHK_GNT_HAS_REQ and CHK_GNT_ONEHOT never fire.

Source files
------------

// File: rtl/req_grant_arbiter.sv
// Round-robin request/grant arbiter with a bounded hold time per grant.
// At most one requester holds the shared resource. A grant is revoked when
// its request drops, or after MAX_HOLD consecutive cycles. In the second
// case a one-cycle timeout pulse is raised and an extra release cycle is
// inserted before the next grant.
module req_grant_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         request,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       timeout
);

    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]        gid_q, gid_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [7:0]           hold_q, hold_d;
    logic                 timeout_q, timeout_d;

    logic [2*NUM_REQ-1:0] req_rot;
    logic [IW:0]          pick_sum;
    logic [IW-1:0]        pick_idx;
    logic                 pick_found;
    logic [IW-1:0]        next_ptr;

    // Round-robin pick: rotate requests so ptr sits at bit 0; the lowest set bit wins.
    always_comb begin
        req_rot    = {request, request} >> ptr_q;
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_sum   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                pick_sum = {1'b0, ptr_q} + (IW+1)'(i);
                if (pick_sum >= (IW+1)'(NUM_REQ)) begin
                    pick_sum = pick_sum - (IW+1)'(NUM_REQ);
                end
                pick_idx   = pick_sum[IW-1:0];
                pick_found = 1'b1;
            end
        end
    end

    // Pointer advances to the requester just after the one being released.
    always_comb begin
        if (gid_q == IW'(NUM_REQ - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = gid_q + 1'b1;
        end
    end

    // Next-state logic: grant on request, revoke on drop (takes priority) or hold expiry.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gid_d     = gid_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    gid_d   = pick_idx;
                    hold_d  = 8'd1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!request[gid_q]) begin
                    gnt_d   = '0;
                    gid_d   = '0;
                    hold_d  = '0;
                    ptr_d   = next_ptr;
                    state_d = IDLE;
                end else if (hold_q == 8'(MAX_HOLD)) begin
                    gnt_d     = '0;
                    gid_d     = '0;
                    hold_d    = '0;
                    ptr_d     = next_ptr;
                    timeout_d = 1'b1;
                    state_d   = RELEASE;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                gid_d   = '0;
                hold_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset drops the grant immediately and rewinds the pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gid_q     <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gid_q     <= gid_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    // Masking with the live request lets a dropped request lose its grant in the same cycle.
    always_comb begin
        grant       = gnt_q & request;
        grant_valid = |grant;
        grant_id    = gid_q;
        timeout     = timeout_q;
    end

    // Grant must stay one-hot and must never appear without its request.
    always @(posedge clk) begin
        if (!reset && state_q == GRANT) begin
            CHK_GNT_ONEHOT: assert ($onehot0(grant));
            CHK_GNT_HAS_REQ: assert ((grant & ~request) == '0);
        end
    end

endmodule

// File: tb/tb_req_grant_arbiter.sv
// Testbench for req_grant_arbiter: directed scenarios followed by random
// request traffic, all compared against a behavioural arbiter model.
module tb_req_grant_arbiter;

    localparam int N  = 4;
    localparam int MH = 8;

    logic         clk;
    logic         reset;
    logic [N-1:0] request;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [1:0]   grant_id;
    logic         timeout;

    int checks;
    int errors;

    // Model: who holds the resource, for how long, where the search starts,
    // and how many edges must pass before a new grant may be issued.
    int holder;
    int held;
    int mptr;
    int cooldown;
    int expTimeout;

    req_grant_arbiter #(
        .NUM_REQ  (N),
        .MAX_HOLD (MH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .request     (request),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .timeout     (timeout)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        holder     = -1;
        held       = 0;
        mptr       = 0;
        cooldown   = 0;
        expTimeout = 0;
    endtask

    // Advance the model by one clock edge using the request seen at that edge.
    task automatic modelStep(input logic [N-1:0] r);
        expTimeout = 0;
        if (holder >= 0) begin
            if (!r[holder]) begin
                mptr   = (holder + 1) % N;
                holder = -1;
            end else if (held == MH) begin
                mptr       = (holder + 1) % N;
                holder     = -1;
                cooldown   = 1;
                expTimeout = 1;
            end else begin
                held++;
            end
        end else if (cooldown > 0) begin
            cooldown--;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (holder < 0 && r[(mptr + k) % N]) begin
                    holder = (mptr + k) % N;
                    held   = 1;
                end
            end
        end
    endtask

    task automatic checkAll();
        int expGrant;
        expGrant = 0;
        if (holder >= 0 && request[holder]) expGrant = 1 << holder;
        checkOutput("grant", int'(grant), expGrant);
        checkOutput("grant_valid", int'(grant_valid), (expGrant != 0) ? 1 : 0);
        checkOutput("grant_id", int'(grant_id), (holder >= 0) ? holder : 0);
        checkOutput("timeout", int'(timeout), expTimeout);
    endtask

    // One clock cycle: drive request after the edge, check mid-cycle, step the model at the edge.
    task automatic applyStimulus(input logic [N-1:0] r);
        request = r;
        @(negedge clk);
        checkAll();
        @(posedge clk);
        modelStep(r);
        #1;
    endtask

    task automatic repeatStimulus(input logic [N-1:0] r, input int cycles);
        for (int c = 0; c < cycles; c++) applyStimulus(r);
    endtask

    // Main sequence: directed scenarios, mid-grant reset, then random traffic.
    initial begin
        logic [N-1:0] r;
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        request = '0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkAll();
        reset = 1'b0;

        // Idle after reset
        repeat (5) applyStimulus(4'b0000);

        // Single requester, dropped while granted
        repeat (3) applyStimulus(4'b0010);
        repeat (3) applyStimulus(4'b0000);

        // All requesters: round-robin with timeouts
        repeat (45) applyStimulus(4'b1111);
        repeat (3) applyStimulus(4'b0000);

        // Two requesters, first one drops early
        repeat (4) applyStimulus(4'b0101);
        repeat (6) applyStimulus(4'b0100);
        repeat (2) applyStimulus(4'b0000);

        // Lone requester held long enough to time out twice
        repeat (22) applyStimulus(4'b0001);
        repeat (3) applyStimulus(4'b0000);

        // Drop coincides with the last hold cycle: drop wins, no timeout
        repeat (8) applyStimulus(4'b0001);
        repeat (4) applyStimulus(4'b0000);

        // Reset while requester 3 is granted
        repeat (3) applyStimulus(4'b1000);
        checkOutput("pre_reset_grant", int'(grant), 8);
        reset = 1'b1;
        #1;
        modelReset();
        checkAll();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) applyStimulus(4'b1001);
        checkOutput("post_reset_grant", int'(grant), 1);
        repeat (2) applyStimulus(4'b0000);

        // Random traffic with sticky requests so holds and timeouts occur
        r = '0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 5) == 0) r = N'($urandom);
            applyStimulus(r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
